// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - 5-stage pipeline hazard sequencer: forwarding, stall/flush priority, memory-wait FSM with timeout, performance counters
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic                 ResultSrcE,
  input  logic                 PCSrcE,
  input  logic [4:0]           RdM,
  input  logic                 RegWriteM,
  input  logic                 MemReqM,
  input  logic                 MemReady,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic                 MemErr,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WW'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t               state_q;
  logic [WW-1:0]        wait_cnt_q;
  logic                 mem_err_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic       mem_stall, lu_stall, timeout, freeze, branch_ok;
  logic       stall_fd, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs)      return 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    else                                            return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(Rs1E);
  assign fwd_b = fwd_sel(Rs2E);

  assign mem_stall = MemReqM && !MemReady;
  assign lu_stall  = ResultSrcE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign timeout   = mem_stall && (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);
  assign freeze    = mem_stall && !timeout;
  assign branch_ok = !mem_stall && PCSrcE;

  // While E is frozen a branch in E is not yet final; it is acted on at release.
  always_comb begin
    stall_fd = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_w  = 1'b0;
    if (freeze) begin
      stall_fd = 1'b1;
      stall_e  = 1'b1;
      stall_m  = 1'b1;
      flush_w  = 1'b1;
    end else if (timeout) begin
      flush_w  = 1'b1;
    end else if (PCSrcE) begin
      flush_d  = 1'b1;
      flush_e  = 1'b1;
    end else if (lu_stall) begin
      stall_fd = 1'b1;
      flush_e  = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_fd && stall_cnt_q != {CNT_WIDTH{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
    if (branch_ok && flush_cnt_q != {CNT_WIDTH{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      mem_err_q   <= timeout;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      case (state_q)
        RUN: begin
          if (freeze) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WW'(1);
          end else begin
            wait_cnt_q <= '0;
          end
        end
        MEM_WAIT: begin
          if (freeze) begin
            wait_cnt_q <= wait_cnt_q + WW'(1);
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Reset forces bubbles into every stage regardless of the clock.
  assign ForwardAE  = rst_n ? fwd_a : 2'b00;
  assign ForwardBE  = rst_n ? fwd_b : 2'b00;
  assign StallF     = rst_n & stall_fd;
  assign StallD     = rst_n & stall_fd;
  assign StallE     = rst_n & stall_e;
  assign StallM     = rst_n & stall_m;
  assign FlushD     = ~rst_n | flush_d;
  assign FlushE     = ~rst_n | flush_e;
  assign FlushW     = ~rst_n | flush_w;
  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed bench with a rule-level reference model checked every cycle
module tb_hazard_controller;

  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE, PCSrcE, RegWriteM, MemReqM, MemReady, RegWriteW;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CW-1:0] StallCount, FlushCount;

  int checks = 0;
  int errors = 0;

  hazard_controller #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
    .MemReqM(MemReqM), .MemReady(MemReady), .RdW(RdW), .RegWriteW(RegWriteW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: frozen cycles so far in the current wait, previous-cycle timeout, counters.
  int m_frozen = 0, m_err = 0, m_scnt = 0, m_fcnt = 0;
  int n_frozen = 0, n_err = 0, n_scnt = 0, n_fcnt = 0;

  function automatic int fwd_rule(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    bit ms, lu, to, fr, br;
    int e_sf, e_se, e_sm, e_fd, e_fe, e_fw;
    ms = MemReqM && !MemReady;
    lu = ResultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    to = ms && TMO != 0 && m_frozen == TMO - 1;
    fr = ms && !to;
    br = !ms && PCSrcE;
    e_sf = fr || (!ms && !PCSrcE && lu);
    e_se = fr;
    e_sm = fr;
    e_fd = br;
    e_fe = br || (!ms && !PCSrcE && lu);
    e_fw = ms;
    if (!rst_n) begin
      chk("fwdA_rst", ForwardAE, 0);
      chk("fwdB_rst", ForwardBE, 0);
      e_sf = 0; e_se = 0; e_sm = 0; e_fd = 1; e_fe = 1; e_fw = 1;
      n_frozen = 0; n_err = 0; n_scnt = 0; n_fcnt = 0;
    end else begin
      chk("fwdA", ForwardAE, fwd_rule(Rs1E));
      chk("fwdB", ForwardBE, fwd_rule(Rs2E));
      n_frozen = fr ? m_frozen + 1 : 0;
      n_err    = to;
      n_scnt   = (e_sf && m_scnt < CMAX) ? m_scnt + 1 : m_scnt;
      n_fcnt   = (br && m_fcnt < CMAX) ? m_fcnt + 1 : m_fcnt;
    end
    chk("StallF", StallF, e_sf);
    chk("StallD", StallD, e_sf);
    chk("StallE", StallE, e_se);
    chk("StallM", StallM, e_sm);
    chk("FlushD", FlushD, e_fd);
    chk("FlushE", FlushE, e_fe);
    chk("FlushW", FlushW, e_fw);
    chk("MemErr", MemErr, m_err);
    chk("StallCount", StallCount, m_scnt);
    chk("FlushCount", FlushCount, m_fcnt);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_frozen <= 0; m_err <= 0; m_scnt <= 0; m_fcnt <= 0;
    end else begin
      m_frozen <= n_frozen; m_err <= n_err; m_scnt <= n_scnt; m_fcnt <= n_fcnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; MemReqM = 0; MemReady = 0; RegWriteW = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    #2;
    chk("rst_StallF", StallF, 0);
    chk("rst_FlushD", FlushD, 1);
    chk("rst_FlushE", FlushE, 1);
    chk("rst_FlushW", FlushW, 1);
    chk("rst_StallCount", StallCount, 0);
    chk("rst_MemErr", MemErr, 0);
    tick(); tick();
    rst_n = 1'b1;

    Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; #1;
    chk("lit_fwdA_M", ForwardAE, 2);
    chk("lit_fwdB_M", ForwardBE, 2);
    RegWriteM = 0; #1;
    chk("lit_fwdA_W", ForwardAE, 1);
    RdM = 0; RdW = 0; Rs1E = 0; RegWriteM = 1; #1;
    chk("lit_fwdA_none", ForwardAE, 0);
    tick(); clr();

    ResultSrcE = 1; RdE = 7; Rs2D = 7; #1;
    chk("lit_lu_StallF", StallF, 1);
    chk("lit_lu_StallD", StallD, 1);
    chk("lit_lu_FlushE", FlushE, 1);
    tick(); clr(); #1;
    chk("lit_lu_cnt", StallCount, 1);
    ResultSrcE = 1; RdE = 0; #1;
    chk("lit_lu_rd0", StallF, 0);
    tick(); clr();

    ResultSrcE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1; #1;
    chk("lit_br_FlushD", FlushD, 1);
    chk("lit_br_FlushE", FlushE, 1);
    chk("lit_br_StallF", StallF, 0);
    tick(); clr(); #1;
    chk("lit_br_fcnt", FlushCount, 1);

    MemReqM = 1; PCSrcE = 1; #1;
    chk("lit_mw_StallM", StallM, 1);
    chk("lit_mw_FlushW", FlushW, 1);
    chk("lit_mw_FlushD", FlushD, 0);
    tick(); tick(); tick();
    MemReady = 1; #1;
    chk("lit_rel_StallF", StallF, 0);
    chk("lit_rel_FlushW", FlushW, 0);
    chk("lit_rel_FlushD", FlushD, 1);
    chk("lit_rel_scnt", StallCount, 4);
    tick(); clr(); #1;
    chk("lit_rel_fcnt", FlushCount, 2);

    MemReqM = 1; MemReady = 1; #1;
    chk("lit_ready_now", StallF, 0);
    tick(); clr();

    MemReqM = 1; #1;
    chk("lit_to_stall", StallF, 1);
    tick(); tick(); tick();
    chk("lit_to_StallF", StallF, 0);
    chk("lit_to_FlushW", FlushW, 1);
    chk("lit_to_err0", MemErr, 0);
    chk("lit_to_scnt", StallCount, 7);
    tick(); clr(); #1;
    chk("lit_to_err1", MemErr, 1);
    tick();
    chk("lit_to_err2", MemErr, 0);

    MemReqM = 1;
    tick(); tick();
    chk("lit_pre_rst_cnt", StallCount, 9);
    rst_n = 1'b0; #1;
    chk("lit_mrst_cnt", StallCount, 0);
    chk("lit_mrst_StallF", StallF, 0);
    chk("lit_mrst_FlushW", FlushW, 1);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("lit_post_to_StallM", StallM, 0);
    chk("lit_post_to_FlushW", FlushW, 1);
    tick(); clr(); #1;
    chk("lit_post_to_err", MemErr, 1);
    chk("lit_post_to_scnt", StallCount, 3);

    ResultSrcE = 1; RdE = 7; Rs1D = 7;
    repeat (20) tick();
    clr(); #1;
    chk("lit_sat", StallCount, 15);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
